// File: rtl/spi_cmd_decoder_if.sv
// Bus bundle between the SPI word source, the command decoder and the framebuffer write port.
interface spi_cmd_decoder_if #(
    parameter int unsigned ADDR_W = 17
);
    logic [23:0]       i_mosi_data;
    logic              i_mosi_en_pls;
    logic [ADDR_W-1:0] o_wr_addr;
    logic [15:0]       o_wr_data;
    logic              o_wr_valid;
    logic              i_wr_ready;
    logic              o_busy;
    logic              o_ovf;
    logic              o_bad_cmd;

    // Word source / framebuffer side (drives received words and ready).
    modport master (
        output i_mosi_data, i_mosi_en_pls, i_wr_ready,
        input  o_wr_addr, o_wr_data, o_wr_valid, o_busy, o_ovf, o_bad_cmd
    );

    // Decoder side.
    modport slave (
        input  i_mosi_data, i_mosi_en_pls, i_wr_ready,
        output o_wr_addr, o_wr_data, o_wr_valid, o_busy, o_ovf, o_bad_cmd
    );
endinterface

// File: rtl/spi_cmd_decoder.sv
// SPI command decoder: buffers 24-bit received words in a small FIFO, decodes
// cursor/colour/pixel opcodes and issues RGB565 framebuffer writes (valid/ready)
// at address y*H_ACTIVE + x with raster auto-increment of the cursor.
// Optional feature: define SPI_CMD_FILL_EN to enable opcode 0x4 FILL (N writes of
// the colour register); otherwise 0x4 is an unknown opcode.
module spi_cmd_decoder #(
    parameter int unsigned H_ACTIVE = 480,
    parameter int unsigned V_ACTIVE = 272,
    parameter int unsigned ADDR_W   = 17,
    parameter int unsigned FIFO_AW  = 3
) (
    input logic              i_clk,
    input logic              i_rst_n,
    spi_cmd_decoder_if.slave bus
);
    localparam int unsigned X_W   = $clog2(H_ACTIVE);
    localparam int unsigned Y_W   = $clog2(V_ACTIVE);
    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned PTR_W = FIFO_AW + 1;

    localparam logic [3:0] OP_NOP       = 4'h0;
    localparam logic [3:0] OP_SET_X     = 4'h1;
    localparam logic [3:0] OP_SET_Y     = 4'h2;
    localparam logic [3:0] OP_PIXEL     = 4'h3;
    localparam logic [3:0] OP_SET_COLOR = 4'h5;
`ifdef SPI_CMD_FILL_EN
    localparam logic [3:0]  OP_FILL = 4'h4;
    localparam int unsigned CNT_W   = 17;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1
`ifdef SPI_CMD_FILL_EN
        , ST_FILL = 2'd2
`endif
    } state_t;

    state_t            state, state_n;
    logic [23:0]       fifo_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
    logic              fifo_empty, fifo_full, push, pop;
    logic [23:0]       head;
    logic [3:0]        opcode;
    logic [19:0]       payload;
    logic [X_W-1:0]    x, x_n, adv_x;
    logic [Y_W-1:0]    y, y_n, adv_y;
    logic [15:0]       colour, colour_n;
    logic [ADDR_W-1:0] wr_addr, addr_n;
    logic [15:0]       wr_data, data_n;
    logic              wr_valid, valid_n;
    logic              bad, bad_n;
    logic              ovf;
    logic              busy;
    logic              unused_payload;
`ifdef SPI_CMD_FILL_EN
    logic [CNT_W-1:0]  cnt, cnt_n;
`endif

    // Linear framebuffer address of a cursor position.
    function automatic logic [ADDR_W-1:0] lin_addr(input logic [X_W-1:0] cx,
                                                   input logic [Y_W-1:0] cy);
        return ADDR_W'(cy) * ADDR_W'(H_ACTIVE) + ADDR_W'(cx);
    endfunction

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                        (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign push       = bus.i_mosi_en_pls && !fifo_full;
    assign wr_ptr_n   = wr_ptr + PTR_W'(push);
    assign rd_ptr_n   = rd_ptr + PTR_W'(pop);
    assign head       = fifo_mem[rd_ptr[FIFO_AW-1:0]];
    assign opcode     = head[23:20];
    assign payload    = head[19:0];
`ifdef SPI_CMD_FILL_EN
    assign unused_payload = ^payload[19:17];
`else
    assign unused_payload = ^payload[19:16];
`endif

    // FIFO storage; words are written only when there is room.
    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_mem[wr_ptr[FIFO_AW-1:0]] <= bus.i_mosi_data;
        end
    end

    // Raster successor of the current cursor, wrapping to (0,0) after the last pixel.
    always_comb begin
        adv_x = x + X_W'(1);
        adv_y = y;
        if (x == X_W'(H_ACTIVE - 1)) begin
            adv_x = '0;
            adv_y = (y == Y_W'(V_ACTIVE - 1)) ? '0 : y + Y_W'(1);
        end
    end

    // Next-state, decode and write-request logic.
    always_comb begin
        state_n  = state;
        x_n      = x;
        y_n      = y;
        colour_n = colour;
        addr_n   = wr_addr;
        data_n   = wr_data;
        valid_n  = wr_valid;
        bad_n    = bad;
        pop      = 1'b0;
`ifdef SPI_CMD_FILL_EN
        cnt_n    = cnt;
`endif
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    case (opcode)
                        OP_NOP: ;
                        OP_SET_X: begin
                            if (32'(payload[8:0]) < H_ACTIVE) x_n = X_W'(payload[8:0]);
                            else bad_n = 1'b1;
                        end
                        OP_SET_Y: begin
                            if (32'(payload[8:0]) < V_ACTIVE) y_n = Y_W'(payload[8:0]);
                            else bad_n = 1'b1;
                        end
                        OP_PIXEL: begin
                            colour_n = payload[15:0];
                            data_n   = payload[15:0];
                            addr_n   = lin_addr(x, y);
                            valid_n  = 1'b1;
                            state_n  = ST_WRITE;
                        end
                        OP_SET_COLOR: colour_n = payload[15:0];
`ifdef SPI_CMD_FILL_EN
                        OP_FILL: begin
                            if (payload[16:0] != '0) begin
                                cnt_n   = payload[16:0];
                                data_n  = colour;
                                addr_n  = lin_addr(x, y);
                                valid_n = 1'b1;
                                state_n = ST_FILL;
                            end
                        end
`endif
                        default: bad_n = 1'b1;
                    endcase
                end
            end
            ST_WRITE: begin
                if (bus.i_wr_ready) begin
                    x_n     = adv_x;
                    y_n     = adv_y;
                    valid_n = 1'b0;
                    state_n = ST_IDLE;
                end
            end
`ifdef SPI_CMD_FILL_EN
            ST_FILL: begin
                if (bus.i_wr_ready) begin
                    x_n   = adv_x;
                    y_n   = adv_y;
                    cnt_n = cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        valid_n = 1'b0;
                        state_n = ST_IDLE;
                    end else begin
                        addr_n = lin_addr(adv_x, adv_y);
                    end
                end
            end
`endif
            default: state_n = ST_IDLE;
        endcase
    end

    // State, cursor, FIFO pointers and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= ST_IDLE;
            x        <= '0;
            y        <= '0;
            colour   <= '0;
            wr_addr  <= '0;
            wr_data  <= '0;
            wr_valid <= 1'b0;
            bad      <= 1'b0;
            ovf      <= 1'b0;
            busy     <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
`ifdef SPI_CMD_FILL_EN
            cnt      <= '0;
`endif
        end else begin
            state    <= state_n;
            x        <= x_n;
            y        <= y_n;
            colour   <= colour_n;
            wr_addr  <= addr_n;
            wr_data  <= data_n;
            wr_valid <= valid_n;
            bad      <= bad_n;
            wr_ptr   <= wr_ptr_n;
            rd_ptr   <= rd_ptr_n;
            busy     <= (wr_ptr_n != rd_ptr_n) || (state_n != ST_IDLE);
            if (bus.i_mosi_en_pls && fifo_full) ovf <= 1'b1;
`ifdef SPI_CMD_FILL_EN
            cnt      <= cnt_n;
`endif
        end
    end

    assign bus.o_wr_addr  = wr_addr;
    assign bus.o_wr_data  = wr_data;
    assign bus.o_wr_valid = wr_valid;
    assign bus.o_busy     = busy;
    assign bus.o_ovf      = ovf;
    assign bus.o_bad_cmd  = bad;
endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Bench for spi_cmd_decoder: directed scenarios plus randomized command bursts,
// checked against a linear-position reference model of the command set.
module tb_spi_cmd_decoder;
    localparam int unsigned H    = 480;
    localparam int unsigned V    = 272;
    localparam int unsigned NPIX = H * V;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    spi_cmd_decoder_if #(.ADDR_W(17)) dif ();

    spi_cmd_decoder #(
        .H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(17), .FIFO_AW(3)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (dif)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned addr;
        logic [15:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [23:0] tx_q[$];
    int unsigned n_chk = 0;
    int unsigned n_pass = 0;
    int unsigned n_wr = 0;
    int unsigned ready_mode = 0;   // 0: low, 1: high, 2: random

    // Reference model: cursor kept as a linear pixel index.
    int unsigned m_pos;
    logic [15:0] m_col;
    bit          m_bad;
    bit          m_ovf;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, act, exp, $time);
    endtask

    function automatic void m_emit();
        exp_q.push_back('{addr: m_pos, data: m_col});
        m_pos = (m_pos + 1) % NPIX;
    endfunction

    function automatic void model(input logic [23:0] w);
        logic [19:0] p = w[19:0];
        case (w[23:20])
            4'h0: ;
            4'h1: if (int'(p[8:0]) < H) m_pos = (m_pos / H) * H + int'(p[8:0]); else m_bad = 1;
            4'h2: if (int'(p[8:0]) < V) m_pos = int'(p[8:0]) * H + (m_pos % H); else m_bad = 1;
            4'h3: begin m_col = p[15:0]; m_emit(); end
            4'h5: m_col = p[15:0];
`ifdef SPI_CMD_FILL_EN
            4'h4: for (int i = 0; i < int'(p[16:0]); i++) m_emit();
`endif
            default: m_bad = 1;
        endcase
    endfunction

    function automatic void add(input logic [23:0] w);
        tx_q.push_back(w);
        model(w);
    endfunction

    function automatic logic [23:0] rand_word();
        logic [19:0] p = 20'($urandom);
        case ($urandom_range(0, 9))
            0:       return {4'h0, p};
            1, 2:    begin p[8:0] = 9'($urandom_range(0, 511)); return {4'h1, p}; end
            3, 4:    begin p[8:0] = 9'($urandom_range(0, 300)); return {4'h2, p}; end
            5, 6:    return {4'h3, p};
            7:       return {4'h5, p};
            8:       begin p[16:0] = 17'($urandom_range(0, 40)); return {4'h4, p}; end
            default: return {4'($urandom_range(6, 15)), p};
        endcase
    endfunction

    // Sole driver of ready, updated just after each rising edge.
    initial begin
        dif.i_wr_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       dif.i_wr_ready = 1'b0;
                1:       dif.i_wr_ready = 1'b1;
                default: dif.i_wr_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Write monitor: handshakes against the model, stalled requests must hold.
    logic        hold_v = 1'b0;
    logic [16:0] hold_a;
    logic [15:0] hold_d;
    wr_t         got_e;
    always @(negedge clk) begin
        if (hold_v && rst_n) begin
            chk("hold_valid", 32'(dif.o_wr_valid), 32'd1);
            chk("hold_addr", 32'(dif.o_wr_addr), 32'(hold_a));
            chk("hold_data", 32'(dif.o_wr_data), 32'(hold_d));
        end
        hold_v = 1'b0;
        if (rst_n && dif.o_wr_valid) begin
            if (dif.i_wr_ready) begin
                n_wr++;
                chk("wr_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    got_e = exp_q.pop_front();
                    chk("wr_addr", 32'(dif.o_wr_addr), got_e.addr);
                    chk("wr_data", 32'(dif.o_wr_data), 32'(got_e.data));
                end
            end else begin
                hold_v = 1'b1;
                hold_a = dif.o_wr_addr;
                hold_d = dif.o_wr_data;
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        tx_q.delete();
        exp_q.delete();
        m_pos = 0; m_col = '0; m_bad = 0; m_ovf = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drive queued words as back-to-back valid pulses.
    task automatic flush_tx();
        while (tx_q.size() != 0) begin
            @(posedge clk);
            #1;
            dif.i_mosi_data   = tx_q.pop_front();
            dif.i_mosi_en_pls = 1'b1;
        end
        @(posedge clk);
        #1;
        dif.i_mosi_en_pls = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (dif.o_busy && n < 3000);
        chk({tag, "_idle"}, 32'(dif.o_busy), 32'd0);
        chk({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!dif.o_wr_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_valid"}, 32'(dif.o_wr_valid), 32'd1);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_addr"},  32'(dif.o_wr_addr),  32'd0);
        chk({tag, "_data"},  32'(dif.o_wr_data),  32'd0);
        chk({tag, "_valid"}, 32'(dif.o_wr_valid), 32'd0);
        chk({tag, "_busy"},  32'(dif.o_busy),     32'd0);
        chk({tag, "_ovf"},   32'(dif.o_ovf),      32'd0);
        chk({tag, "_bad"},   32'(dif.o_bad_cmd),  32'd0);
    endtask

    initial begin
        int unsigned w0;
        dif.i_mosi_data   = '0;
        dif.i_mosi_en_pls = 1'b0;
        do_reset();
        chk_outputs_zero("rst");

        // Single pixel at (10,2), then one more to confirm the cursor moved to x=11.
        ready_mode = 1;
        w0 = n_wr;
        add(24'h10000A); add(24'h200002); add(24'h30F800); add(24'h301234);
        flush_tx(); wait_idle("pix");
        chk("pix_count", n_wr - w0, 32'd2);

        // Last pixel of the frame followed by raster wrap to address 0.
        w0 = n_wr;
        add(24'h1001DF); add(24'h20010F); add(24'h30001F); add(24'h3007E0);
        flush_tx(); wait_idle("wrap");
        chk("wrap_count", n_wr - w0, 32'd2);

        // Overflow: stall a write, then 9 words; the 9th must be dropped.
        ready_mode = 0;
        w0 = n_wr;
        add(24'h301111);
        flush_tx(); wait_valid("ovf_stall");
        for (int i = 0; i < 8; i++) add({4'h3, 20'(16'hA000 + i)});
        tx_q.push_back(24'h30DEAD);
        flush_tx();
        m_ovf = 1;
        chk("ovf_flag", 32'(dif.o_ovf), 32'(m_ovf));
        chk("ovf_busy", 32'(dif.o_busy), 32'd1);
        chk("ovf_stalled", n_wr - w0, 32'd0);
        ready_mode = 1;
        wait_idle("ovf");
        chk("ovf_count", n_wr - w0, 32'd9);
        chk("ovf_sticky", 32'(dif.o_ovf), 32'(m_ovf));
        do_reset();
        chk("ovf_cleared", 32'(dif.o_ovf), 32'd0);

        // Bad commands: out-of-range SET_X and unknown opcode leave cursor alone.
        w0 = n_wr;
        add(24'h100005); add(24'h1001E0); add(24'hF00000); add(24'h3000AA);
        flush_tx(); wait_idle("bad");
        chk("bad_flag", 32'(dif.o_bad_cmd), 32'(m_bad));
        chk("bad_count", n_wr - w0, 32'd1);
        add(24'h000000);
        flush_tx(); wait_idle("bad_nop");
        chk("bad_sticky", 32'(dif.o_bad_cmd), 32'd1);

        // FILL opcode.
        do_reset();
        w0 = n_wr;
`ifdef SPI_CMD_FILL_EN
        add(24'h50FFFF); add(24'h1001DE); add(24'h400004);
        flush_tx(); wait_idle("fill");
        chk("fill_count", n_wr - w0, 32'd4);
        w0 = n_wr;
        add(24'h400000);
        flush_tx(); wait_idle("fill0");
        chk("fill0_count", n_wr - w0, 32'd0);
        chk("fill_bad", 32'(dif.o_bad_cmd), 32'd0);
`else
        add(24'h400004);
        flush_tx(); wait_idle("fill");
        chk("fill_count", n_wr - w0, 32'd0);
        chk("fill_bad", 32'(dif.o_bad_cmd), 32'd1);
`endif

        // Randomized bursts (at most one FIFO's worth) with random backpressure.
        do_reset();
        ready_mode = 2;
        for (int b = 0; b < 40; b++) begin
            int unsigned n = $urandom_range(1, 8);
            for (int k = 0; k < int'(n); k++) add(rand_word());
            flush_tx(); wait_idle("rnd");
            chk("rnd_bad", 32'(dif.o_bad_cmd), 32'(m_bad));
            chk("rnd_ovf", 32'(dif.o_ovf), 32'(m_ovf));
        end

        // Reset while a write is stalled.
        ready_mode = 0;
        add(24'h100064); add(24'h200003); add(24'h301234);
        flush_tx(); wait_valid("mw");
        #2;
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("mw_rst");
        exp_q.delete();
        m_pos = 0; m_col = '0; m_bad = 0; m_ovf = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ready_mode = 1;
        w0 = n_wr;
        add(24'h30ABCD);
        flush_tx(); wait_idle("mw");
        chk("mw_count", n_wr - w0, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
